// File: rtl/pipes_pkg.sv
// Types shared by the fetch pipeline: controller state encoding and the
// decode-facing buffer entry.
package pipes;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ       = 3'd1,
    WAIT      = 3'd2,
    DROP_REQ  = 3'd3,
    DROP_WAIT = 3'd4,
    EXC       = 3'd5
  } fetch_state_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        exc;
  } fetch_entry_t;

  // Instructions are 32-bit; any nonzero low address bit is a misaligned fetch.
  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return addr_lo != 2'b00;
  endfunction

endpackage

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: one outstanding bus read per PC value, returned to
// decode through a one-entry buffer; responses belonging to a redirected stream are dropped.
module ifetch_ctrl
  import pipes::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] pc,
  output logic        stallpc,
  input  logic        flush,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        ireq_ready,
  input  logic        iresp_valid,
  input  logic [31:0] iresp_data,
  output logic        out_valid,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_exc,
  input  logic        out_ready
);

  fetch_state_t state_r;
  logic [63:0]  req_addr_r;
  fetch_entry_t entry_r;
  logic         out_valid_r;

  logic issue_s;
  logic capture_s;
  logic exc_load_s;

  // The buffer is free this cycle if empty or being drained by decode.
  assign issue_s    = !out_valid_r || out_ready;
  assign capture_s  = (state_r == WAIT) && iresp_valid && !flush;
  assign exc_load_s = (state_r == IDLE) && issue_s && !flush && is_misaligned(pc[1:0]);

  // FSM, latched request address and decode buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      req_addr_r  <= 64'h0;
      out_valid_r <= 1'b0;
      entry_r     <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (flush) begin
            state_r <= IDLE;
          end else if (issue_s && is_misaligned(pc[1:0])) begin
            state_r <= EXC;
          end else if (issue_s) begin
            req_addr_r <= pc;
            state_r    <= REQ;
          end else begin
            state_r <= IDLE;
          end
        end
        // An address phase already raised must complete even after a redirect.
        REQ: begin
          if (ireq_ready) begin
            state_r <= flush ? DROP_WAIT : WAIT;
          end else if (flush) begin
            state_r <= DROP_REQ;
          end else begin
            state_r <= REQ;
          end
        end
        WAIT: begin
          if (iresp_valid) begin
            state_r <= IDLE;
          end else if (flush) begin
            state_r <= DROP_WAIT;
          end else begin
            state_r <= WAIT;
          end
        end
        DROP_REQ: begin
          state_r <= ireq_ready ? DROP_WAIT : DROP_REQ;
        end
        DROP_WAIT: begin
          state_r <= iresp_valid ? IDLE : DROP_WAIT;
        end
        EXC: begin
          state_r <= flush ? IDLE : EXC;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase

      // Flush beats both a capture and the decode handshake.
      if (flush) begin
        out_valid_r <= 1'b0;
      end else if (capture_s) begin
        out_valid_r   <= 1'b1;
        entry_r.pc    <= req_addr_r;
        entry_r.instr <= iresp_data;
        entry_r.exc   <= 1'b0;
      end else if (exc_load_s) begin
        out_valid_r   <= 1'b1;
        entry_r.pc    <= pc;
        entry_r.instr <= 32'h0;
        entry_r.exc   <= 1'b1;
      end else if (out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  // The PC may only advance once its instruction is captured, or on a redirect.
  assign stallpc    = reset || !(flush || capture_s);

  assign ireq_valid = (state_r == REQ) || (state_r == DROP_REQ);
  assign ireq_addr  = req_addr_r;

  assign out_valid  = out_valid_r;
  assign out_pc     = entry_r.pc;
  assign out_instr  = entry_r.instr;
  assign out_exc    = entry_r.exc;

endmodule

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction-fetch controller between the PC register and the instruction bus, on the consuming side of the PC. It reads the current `pc` and issues one 32-bit instruction read over a valid/ready address phase plus a response phase. It returns the instruction to decode through a one-entry output buffer with a valid/ready handshake. It drives `stallpc` so the PC advances only when an instruction has been captured, and it discards in-flight responses when the pipeline redirects.

## Interface
- No parameters.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- pc  in  64  current fetch address from the PC register
- stallpc  out  1  hold the PC register this cycle
- flush  in  1  redirect/flush; the PC register loads the redirect target this cycle
- ireq_valid  out  1  address-phase request
- ireq_addr  out  64  request address; stable while `ireq_valid` is high
- ireq_ready  in  1  address accepted (addr_ok)
- iresp_valid  in  1  read data returned (data_ok)
- iresp_data  in  32  instruction word
- out_valid  out  1  decode entry valid
- out_pc  out  64  PC of the entry
- out_instr  out  32  instruction of the entry
- out_exc  out  1  misaligned-fetch exception for the entry; `out_instr` is 0 when set
- out_ready  in  1  decode accepts the entry

## Operation
- States: IDLE, REQ, WAIT, DROP_REQ, DROP_WAIT, EXC. At most one request is outstanding.
- Issue condition: `!out_valid || out_ready`. Because the buffer is always empty when a response lands, the response is captured unconditionally.
- **IDLE**, issue condition true, `pc[1:0]==0`: latch `req_addr<=pc`, go to REQ.
- **IDLE**, issue condition true, `pc[1:0]!=0`: load the buffer with `{pc, 0, exc=1}` and go to EXC.
- **REQ**: drive `ireq_valid=1`, `ireq_addr=req_addr`. On `ireq_ready`, go to WAIT.
- **WAIT**: on `iresp_valid`, load the buffer with `{req_addr, iresp_data, exc=0}`, drive `stallpc=0`, go to IDLE.
- **EXC**: no requests. `stallpc=1`. Leave only on `flush`.
- Flush from IDLE or EXC: go to IDLE.
- Flush from REQ without `ireq_ready`: go to DROP_REQ. An address phase, once raised, is never retracted.
- Flush from REQ with `ireq_ready`: go to DROP_WAIT.
- Flush from WAIT: go to DROP_WAIT; if `iresp_valid` arrives the same cycle, discard the data and go to IDLE.
- **DROP_REQ**: `ireq_valid` stays high with the old address. On `ireq_ready`, go to DROP_WAIT.
- **DROP_WAIT**: on `iresp_valid`, discard the data and go to IDLE.
- Flush on any cycle: clears `out_valid` at the next edge and forces `stallpc=0` that cycle. Flush takes priority over capture and over decode handshake.
- Buffer drain: on `out_valid && out_ready && !flush`, `out_valid` is 0 next cycle unless it is reloaded in the same cycle.
- `stallpc=1` in every other case, including while `reset` is high.
- `iresp_valid` in IDLE, REQ or EXC is a protocol violation: ignore it and fire a bench assertion.

## Timing
- Reset values: state=IDLE, `out_valid=0`, `out_exc=0`, `out_pc=0`, `out_instr=0`, `ireq_valid=0`, `ireq_addr=0`, `stallpc=1`.
- Reset mid-transaction abandons the request; the bus slave is reset by the same signal.
- `ireq_valid` and `ireq_addr` are decoded from registered state and `req_addr`; there is no combinational path from `pc`.
- Best case: IDLE at cycle 0, REQ with ready at cycle 1, WAIT with data at cycle 2. `stallpc=0` in cycle 2, so the PC updates at the end of cycle 2. `out_valid=1` in cycle 3.
- Steady-state throughput is 1 instruction per 3 cycles, plus the bus wait cycles.
- Output entry fields are held stable while `out_valid && !out_ready`.

## Structure
- Shared `pipes` package: `fetch_state_t` enum (the six states) and `fetch_entry_t` struct {pc u64, instr u32, exc logic}.
- Single module, no sub-modules.

## Test plan
- Zero-wait bus, `pc=0x8000_0000`, `out_ready=1`: `ireq_addr=0x8000_0000` in cycle 1; `out_instr=0x00000013` with `out_pc=0x8000_0000` in cycle 3; `stallpc=0` only in cycle 2.
- `ireq_ready` delayed 3 cycles, then data delayed 2 cycles: `ireq_valid` and `ireq_addr` stay constant throughout; exactly one capture.
- `flush` in REQ before `ireq_ready`: `ireq_valid` stays high until ready. The later response `0xDEADBEEF` never appears on `out_instr`. The next request uses the redirect `pc`.
- `flush` in the same cycle as `iresp_valid`: data discarded, `stallpc=0`, `out_valid=0` next cycle, then return to IDLE.
- `out_ready=0` for 5 cycles with `out_valid=1`: no new `ireq_valid`, entry stable, `stallpc=1`.
- `pc=0x8000_0002`: no bus request; `out_exc=1`, `out_pc=0x8000_0002`, `out_instr=0`. Block stays in EXC until `flush`.
